hax_elevator_scan: RTL and testbench

HAX_ELEVATOR_SCAN -- requirements
Module: hax_elevator_scan

---
 rtl/hax_elevator_pkg.sv | 26 ++
 rtl/hax_scan_pick.sv | 45 ++++
 rtl/hax_elevator_scan.sv | 158 +++++++++++++++
 tb/tb_hax_elevator_scan.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hax_elevator_pkg.sv
// hax_elevator_pkg: shared types for the SCAN elevator controller.
// Provides floor_t, state_t (IDLE/MOVE/DOOR), dir_t (UP/DOWN) and a direction helper.
package hax_elevator_pkg;

  localparam int MAX_FLOORS = 16;

  typedef logic [3:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR
  } state_t;

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

  // Keep heading if work lies ahead; otherwise turn round.
  function automatic dir_t pick_dir(dir_t d, logic ahead, logic behind);
    if (ahead || !behind) return d;
    return (d == UP) ? DOWN : UP;
  endfunction

endpackage

// File: rtl/hax_scan_pick.sv
// hax_scan_pick: combinational SCAN look-ahead over the pending bitmap.
// Ports: pending, cur, dir in; any_ahead, any_behind, nearest_ahead out.
module hax_scan_pick
  import hax_elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 10,
  localparam int FW = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FW-1:0]         cur,
  input  dir_t                  dir,
  output logic                  any_ahead,
  output logic                  any_behind,
  output logic [FW-1:0]         nearest_ahead
);

  logic [NUM_FLOORS-1:0] above;
  logic [NUM_FLOORS-1:0] below;
  logic [FW-1:0]         up_near;
  logic [FW-1:0]         dn_near;

  always_comb begin
    above = '0;
    below = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above[i] = pending[i] && (i > int'(cur));
      below[i] = pending[i] && (i < int'(cur));
    end
  end

  // Lowest set bit above, highest set bit below.
  always_comb begin
    up_near = cur;
    dn_near = cur;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (above[i]) up_near = FW'(i);
    for (int i = 0; i < NUM_FLOORS; i++)
      if (below[i]) dn_near = FW'(i);
  end

  assign any_ahead     = (dir == UP) ? |above : |below;
  assign any_behind    = (dir == UP) ? |below : |above;
  assign nearest_ahead = (dir == UP) ? up_near : dn_near;

endmodule

// File: rtl/hax_elevator_scan.sv
// hax_elevator_scan: single-car SCAN elevator controller (IDLE/MOVE/DOOR).
// In: CLOCK_50, rst_n (sync, active-low), req_valid, req_floor.
// Out: current_floor, target_floor, moving, dir_up, dir_down, door_open, pending.
// Macro HAX_ELEVATOR_DOOR_EN enables the door dwell; without it door_open is 0.
module hax_elevator_scan
  import hax_elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 10,
  parameter int MOVE_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES = 100_000_000,
  localparam int FW = $clog2(NUM_FLOORS)
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [FW-1:0]         req_floor,
  output logic [FW-1:0]         current_floor,
  output logic [FW-1:0]         target_floor,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  dir_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  state_t                state;
  dir_t                  dir;
  logic [31:0]           step_cnt;
  logic [31:0]           dwell_cnt;
  logic                  req_ok;
  logic                  req_here;
  logic                  step_end;
  logic                  dwell_end;
  logic                  arrive;
  logic [FW-1:0]         next_floor;
  logic [NUM_FLOORS-1:0] req_bit;
  logic [NUM_FLOORS-1:0] set_bit;
  logic [NUM_FLOORS-1:0] nf_bit;
  logic                  any_ahead;
  logic                  any_behind;
  logic [FW-1:0]         nearest;

  assign req_ok   = req_valid && (int'(req_floor) < NUM_FLOORS);
  assign req_here = req_ok && (req_floor == current_floor);
  assign req_bit  = req_ok ? (NUM_FLOORS'(1) << req_floor) : '0;
  // A call for the floor the car is standing at is served, not queued.
  assign set_bit  = (req_here && state != MOVE) ? '0 : req_bit;

  assign step_end   = step_cnt == 32'(MOVE_CYCLES - 1);
  assign dwell_end  = dwell_cnt == 32'(DOOR_CYCLES - 1);
  assign next_floor = (dir == UP) ? current_floor + 1'b1
                                  : current_floor - 1'b1;
  assign nf_bit     = NUM_FLOORS'(1) << next_floor;
  assign arrive     = |(pending & nf_bit)
                   || (req_ok && req_floor == next_floor);

  hax_scan_pick #(.NUM_FLOORS(NUM_FLOORS)) u_pick (
    .pending       (pending),
    .cur           (current_floor),
    .dir           (dir),
    .any_ahead     (any_ahead),
    .any_behind    (any_behind),
    .nearest_ahead (nearest)
  );

`ifndef HAX_ELEVATOR_DOOR_EN
  // Without a door the next direction is chosen on the arrival edge,
  // so look ahead from the floor being entered.
  logic [NUM_FLOORS-1:0] rest;
  logic                  nx_ahead;
  logic                  nx_behind;
  logic [FW-1:0]         nx_near;

  assign rest = pending & ~nf_bit;

  hax_scan_pick #(.NUM_FLOORS(NUM_FLOORS)) u_pick_nx (
    .pending       (rest),
    .cur           (next_floor),
    .dir           (dir),
    .any_ahead     (nx_ahead),
    .any_behind    (nx_behind),
    .nearest_ahead (nx_near)
  );
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state         <= IDLE;
      dir           <= UP;
      current_floor <= '0;
      pending       <= '0;
      step_cnt      <= '0;
      dwell_cnt     <= '0;
    end else begin
      pending <= pending | set_bit;
      unique case (state)
        IDLE: begin
`ifdef HAX_ELEVATOR_DOOR_EN
          if (req_here) begin
            state     <= DOOR;
            dwell_cnt <= '0;
          end else
`endif
          if (|pending) begin
            dir      <= pick_dir(dir, any_ahead, any_behind);
            state    <= MOVE;
            step_cnt <= '0;
          end
        end
        MOVE: begin
          if (!step_end) begin
            step_cnt <= step_cnt + 32'd1;
          end else begin
            step_cnt      <= '0;
            current_floor <= next_floor;
            if (arrive) begin
              pending <= (pending | set_bit) & ~nf_bit;
`ifdef HAX_ELEVATOR_DOOR_EN
              state     <= DOOR;
              dwell_cnt <= '0;
`else
              if (|rest)
                dir <= pick_dir(dir, nx_ahead, nx_behind);
              else
                state <= IDLE;
`endif
            end
          end
        end
        DOOR: begin
          if (req_here) begin
            dwell_cnt <= '0;
          end else if (!dwell_end) begin
            dwell_cnt <= dwell_cnt + 32'd1;
          end else if (|pending) begin
            dir      <= pick_dir(dir, any_ahead, any_behind);
            state    <= MOVE;
            step_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign moving       = state == MOVE;
  assign dir_up       = moving && dir == UP;
  assign dir_down     = moving && dir == DOWN;
  assign target_floor = moving ? nearest : current_floor;
`ifdef HAX_ELEVATOR_DOOR_EN
  assign door_open    = state == DOOR;
`else
  assign door_open    = 1'b0;
`endif

endmodule

// File: tb/tb_hax_elevator_scan.sv
// tb_hax_elevator_scan: directed scenarios plus random traffic against
// a floor-walking reference model of the SCAN controller.
module tb_hax_elevator_scan;

  localparam int NF = 10;
  localparam int MC = 5;
  localparam int DC = 3;
`ifdef HAX_ELEVATOR_DOOR_EN
  localparam bit DOOR_EN = 1'b1;
`else
  localparam bit DOOR_EN = 1'b0;
`endif

  localparam int S_IDLE = 0;
  localparam int S_MOVE = 1;
  localparam int S_DOOR = 2;

  logic          CLOCK_50;
  logic          rst_n;
  logic          req_valid;
  logic [3:0]    req_floor;
  logic [3:0]    current_floor;
  logic [3:0]    target_floor;
  logic          moving;
  logic          dir_up;
  logic          dir_down;
  logic          door_open;
  logic [NF-1:0] pending;

  hax_elevator_scan #(
    .NUM_FLOORS  (NF),
    .MOVE_CYCLES (MC),
    .DOOR_CYCLES (DC)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_floor     (req_floor),
    .current_floor (current_floor),
    .target_floor  (target_floor),
    .moving        (moving),
    .dir_up        (dir_up),
    .dir_down      (dir_down),
    .door_open     (door_open),
    .pending       (pending)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Reference model: where the car is, what it is doing, what is queued.
  int          m_floor = 0;
  int          m_mode  = S_IDLE;
  bit          m_up    = 1'b1;
  int          m_step  = 0;
  int          m_dwell = 0;
  bit [NF-1:0] m_pend  = '0;

  // Walk outward from f in the heading; first queued floor found wins.
  function automatic int ahead_of(int f, bit up, bit [NF-1:0] p);
    for (int d = 1; d < NF; d++) begin
      int g;
      g = up ? f + d : f - d;
      if (g >= 0 && g < NF && p[g]) return g;
    end
    return f;
  endfunction

  function automatic bit heading(int f, bit up, bit [NF-1:0] p);
    return (ahead_of(f, up, p) != f) ? up : !up;
  endfunction

  function automatic void model_edge(bit rn, bit rv, int rf);
    bit          valid;
    bit          here;
    bit          set_req;
    bit [NF-1:0] base;
    int          nf;
    if (!rn) begin
      m_floor = 0; m_mode = S_IDLE; m_up = 1'b1;
      m_step = 0; m_dwell = 0; m_pend = '0;
      return;
    end
    valid   = rv && rf < NF;
    here    = valid && rf == m_floor && m_mode != S_MOVE;
    set_req = valid && !here;
    base    = m_pend;
    case (m_mode)
      S_IDLE: begin
        if (here && DOOR_EN) begin
          m_mode = S_DOOR; m_dwell = 0;
        end else if (here) begin
          m_mode = S_IDLE;
        end else if (base != 0) begin
          m_up = heading(m_floor, m_up, base);
          m_mode = S_MOVE; m_step = 0;
        end
      end
      S_MOVE: begin
        if (m_step == MC - 1) begin
          m_step = 0;
          nf = m_up ? m_floor + 1 : m_floor - 1;
          m_floor = nf;
          if (base[nf] || (valid && rf == nf)) begin
            if (valid && rf == nf) set_req = 0;
            base[nf] = 1'b0;
            if (DOOR_EN) begin
              m_mode = S_DOOR; m_dwell = 0;
            end else if (base != 0) begin
              m_up = heading(nf, m_up, base);
            end else begin
              m_mode = S_IDLE;
            end
          end
        end else begin
          m_step++;
        end
      end
      default: begin
        if (here) m_dwell = 0;
        else if (m_dwell < DC - 1) m_dwell++;
        else if (base != 0) begin
          m_up = heading(m_floor, m_up, base);
          m_mode = S_MOVE; m_step = 0;
        end else m_mode = S_IDLE;
      end
    endcase
    m_pend = base;
    if (set_req) m_pend[rf] = 1'b1;
  endfunction

  always @(posedge CLOCK_50) model_edge(rst_n, req_valid, int'(req_floor));

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit mv;
    mv = m_mode == S_MOVE;
    chk("current_floor", int'(current_floor), m_floor);
    chk("target_floor", int'(target_floor),
        mv ? ahead_of(m_floor, m_up, m_pend) : m_floor);
    chk("moving", int'(moving), int'(mv));
    chk("dir_up", int'(dir_up), int'(mv && m_up));
    chk("dir_down", int'(dir_down), int'(mv && !m_up));
    chk("door_open", int'(door_open), int'(m_mode == S_DOOR));
    chk("pending", int'(pending), int'(m_pend));
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    if (chk_en) compare_all();
  endtask

  task automatic req(input int f);
    req_valid = 1'b1;
    req_floor = 4'(f);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_clear(input int f, input int budget);
    int n = 0;
    while (pending[f] && n < budget) begin tick(); n++; end
    chk("wait_clear", int'(pending[f]), 0);
  endtask

  task automatic wait_floor(input int f, input int budget);
    int n = 0;
    while (int'(current_floor) != f && n < budget) begin tick(); n++; end
    chk("wait_floor", int'(current_floor), f);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((moving || door_open || pending != 0) && n < budget) begin
      tick(); n++;
    end
    chk("wait_idle", int'(moving || door_open || pending != 0), 0);
  endtask

  initial begin
    int mv;
    int dc;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_floor = '0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_outs", int'({current_floor, target_floor, moving, dir_up,
                            dir_down, door_open, pending}), 0);
    rst_n = 1'b1;

    // Trip 0 -> 7.
    req(7);
    chk("r030_pending", int'(pending), 'h080);
    chk("r030_idle", int'(moving), 0);
    tick();
    chk("r030_dir", int'({moving, dir_up, dir_down}), 3'b110);
    chk("r030_target", int'(target_floor), 7);
    mv = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!moving) break;
      mv++;
    end
    chk("r030_move_cycles", mv, 35);
    chk("r030_floor", int'(current_floor), 7);
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!door_open) break;
      dc++;
      tick();
    end
    chk("r030_door_cycles", dc, DOOR_EN ? 3 : 0);
    wait_idle(50);
    chk("r030_pending_end", int'(pending), 0);

    // From 7: requests 4 then 5.
    req(4);
    tick();
    req(5);
    chk("r031_dir_down", int'(dir_down), 1);
    chk("r031_target", int'(target_floor), 5);
    wait_clear(5, 100);
    chk("r031_first", int'(current_floor), 5);
    chk("r031_keep4", int'(pending[4]), 1);
    wait_clear(4, 100);
    chk("r031_second", int'(current_floor), 4);
    wait_idle(50);

    // From 0: request 8, then 3 while passing floor 1.
    req(0);
    wait_idle(100);
    chk("r032_at0", int'(current_floor), 0);
    req(8);
    wait_floor(1, 50);
    req(3);
    chk("r032_target", int'(target_floor), 3);
    wait_clear(3, 100);
    chk("r032_keep8", int'(pending[8]), 1);
    wait_clear(8, 100);
    chk("r032_at8", int'(current_floor), 8);
    wait_idle(50);

    // From 3 heading to 8, request 1 behind.
    req(3);
    wait_idle(100);
    chk("r033_at3", int'(current_floor), 3);
    req(8);
    tick();
    req(1);
    chk("r033_target", int'(target_floor), 8);
    wait_clear(8, 100);
    chk("r033_keep1", int'(pending[1]), 1);
    wait_clear(1, 150);
    chk("r033_at1", int'(current_floor), 1);
    wait_idle(50);

    // Own-floor call and out-of-range call.
    req(1);
    chk("r034_door", int'(door_open), int'(DOOR_EN));
    chk("r034_pending", int'(pending), 0);
    wait_idle(20);
    req(12);
    chk("r034_drop", int'(pending), 0);
    tick();
    chk("r034_still", int'(moving), 0);

    // Reset mid-step toward 6.
    req(6);
    tick(); tick(); tick();
    chk("r035_moving", int'(moving), 1);
    rst_n = 1'b0;
    tick();
    chk("r035_zero", int'({current_floor, target_floor, moving, dir_up,
                           dir_down, door_open, pending}), 0);
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst_n = $urandom_range(0, 999) != 0;
      req_valid = $urandom_range(0, 5) == 0;
      req_floor = ($urandom_range(0, 3) == 0) ? 4'(m_floor)
                                              : 4'($urandom_range(0, 15));
      tick();
    end
    rst_n = 1'b1;
    req_valid = 1'b0;
    wait_idle(2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
